// File: rtl/gelu_pkg.sv
// Shared constants, lane result type and the per-lane requantiser
// (signed Q26 -> signed OUT_W-bit with OUT_FRAC fraction bits).
package gelu_pkg;

  localparam int unsigned Q         = 26;
  localparam int unsigned W         = 32;
  localparam int unsigned NUM_LANES = 32;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned OUT_FRAC  = 4;
  localparam int unsigned SHIFT     = Q - OUT_FRAC;

  // Rounding offset and clamp limits, all W+1 bits so the add cannot overflow.
  localparam logic signed [W:0] RND  = {{(W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [W:0] YMAX = {{(W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [W:0] YMIN = {{(W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] y;
  } lane_res_t;

  // Round half up, then saturate; sat flags any clamping.
  function automatic lane_res_t requant_lane(input logic [W-1:0] x);
    logic signed [W:0] r;
    lane_res_t         res;
    r = ($signed({x[W-1], x}) + RND) >>> SHIFT;
    if (r > YMAX) begin
      res.sat = 1'b1;
      res.y   = YMAX[OUT_W-1:0];
    end else if (r < YMIN) begin
      res.sat = 1'b1;
      res.y   = YMIN[OUT_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.y   = r[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/gelu_vec_fifo.sv
// Synchronous FIFO of packed vectors; occupancy drives full/empty.
module gelu_vec_fifo #(
  parameter int unsigned WIDTH = 257,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers/level; push into a full FIFO only with a pop.
  always_comb begin
    wr_en    = push_i && (!full_o || pop_i);
    rd_en    = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State and storage registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/gelu_requant_packer.sv
// Requantises a vector of GELU results, packs the lanes and queues them
// for a valid/ready consumer; drops and counts vectors when the queue is full.
module gelu_requant_packer #(
  parameter int unsigned NUM_LANES  = gelu_pkg::NUM_LANES,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_in,
  input  logic [gelu_pkg::W-1:0]            in_data [NUM_LANES],
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_LANES*gelu_pkg::OUT_W-1:0] out_data,
  output logic                              out_sat,
  output logic                              almost_full,
  output logic                              overflow,
  input  logic                              clr_overflow,
  output logic [15:0]                       drop_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  import gelu_pkg::*;

  localparam int unsigned VEC_W   = NUM_LANES * OUT_W;
  localparam int unsigned ENTRY_W = VEC_W + 1;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

  logic [VEC_W-1:0]     lane_y;
  logic [NUM_LANES-1:0] lane_sat;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_res_t res;
    assign res                      = requant_lane(in_data[i]);
    assign lane_y[i*OUT_W +: OUT_W] = res.y;
    assign lane_sat[i]              = res.sat;
  end

  logic             s1_valid_q;
  logic [VEC_W-1:0] s1_data_q;
  logic             s1_sat_q;

  // Stage 1: capture the packed vector whenever the GELU array presents one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_data_q <= lane_y;
        s1_sat_q  <= |lane_sat;
      end
    end
  end

  logic               fifo_full, fifo_empty;
  logic               push, pop, drop;
  logic [ENTRY_W-1:0] head;

  assign pop  = !fifo_empty && out_ready;
  assign push = s1_valid_q && (!fifo_full || pop);
  assign drop = s1_valid_q && fifo_full && !pop;

  gelu_vec_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({s1_sat_q, s1_data_q}),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head[VEC_W-1:0];
  assign out_sat   = head[VEC_W];

  logic [LVL_W:0] af_sum;
  assign af_sum      = {1'b0, fifo_level} + {{LVL_W{1'b0}}, s1_valid_q};
  assign almost_full = (af_sum >= (LVL_W + 1)'(FIFO_DEPTH - 1));

  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Clear applies first so a coincident drop still registers as one drop.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + 16'd1;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_gelu_requant_packer.sv
// Bench for gelu_requant_packer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_gelu_requant_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vin = 1'b0;
  logic [31:0]  din [32];
  logic         ordy = 1'b0;
  logic         clr = 1'b0;
  logic         out_valid, out_sat, almost_full, overflow;
  logic [255:0] out_data;
  logic [15:0]  drop_count;
  logic [2:0]   fifo_level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gelu_requant_packer #(.NUM_LANES(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (vin),
    .in_data      (din),
    .out_valid    (out_valid),
    .out_ready    (ordy),
    .out_data     (out_data),
    .out_sat      (out_sat),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .clr_overflow (clr),
    .drop_count   (drop_count),
    .fifo_level   (fifo_level)
  );

  // ---------------- reference model ----------------
  bit           m_s1v;
  logic [256:0] m_s1;
  logic [256:0] mq [$];
  bit           m_ovf;
  int           m_drop;

  function automatic logic [8:0] ref_lane(input logic [31:0] x);
    longint v, r;
    v = $signed(x);
    r = (v + 64'sd2097152) >>> 22;
    if (r > 127)  return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  function automatic logic [256:0] ref_vec();
    logic [256:0] e;
    logic [8:0]   l;
    e = '0;
    for (int i = 0; i < 32; i++) begin
      l = ref_lane(din[i]);
      e[i*8 +: 8] = l[7:0];
      e[256] = e[256] | l[8];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    int t;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin t = int'($urandom_range(0, 1023)) - 512; return 32'(t) << 21; end
      2: return 32'($urandom_range(0, 32'h4000_0000)) - 32'h2000_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1v = 0; m_s1 = '0; mq.delete(); m_ovf = 0; m_drop = 0;
  endtask

  // Advance the model with the current inputs, then let the DUT take the same edge.
  task automatic tick();
    bit pop, drop;
    pop  = (mq.size() > 0) && ordy;
    drop = m_s1v && (mq.size() == 4) && !pop;
    if (pop) void'(mq.pop_front());
    if (m_s1v && !drop) mq.push_back(m_s1);
    if (clr) begin m_drop = 0; m_ovf = 0; end
    if (drop) begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
    m_s1v = vin;
    if (vin) m_s1 = ref_vec();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vin = 0; ordy = 0; clr = 0;
    for (int i = 0; i < 32; i++) din[i] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", out_sat); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops: got %0d expected 0", drop_count); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_unity();
    do_reset();
    ordy = 1;
    din[0] = 32'h0400_0000; vin = 1;
    tick();
    vin = 0; din[0] = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unity_early: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unity_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 256'h10) begin errors++; $display("FAIL unity_data: got %h expected 10", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL unity_sat: got %b expected 0", out_sat); end
    tick();
    checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL unity_drain: got valid=%b level=%0d expected 0/0", out_valid, fifo_level); end
  endtask

  task automatic test_rounding();
    do_reset();
    ordy = 1;
    din[0] = 32'h0020_0000; din[1] = 32'hFFE0_0000;
    din[2] = 32'h0060_0000; din[3] = 32'hFFA0_0000;
    vin = 1;
    tick();
    clear_inputs(); ordy = 1;
    tick();
    checks++; if (out_data !== 256'hFF02_0001) begin errors++; $display("FAIL round_data: got %h expected ff020001", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL round_sat: got %b expected 0", out_sat); end
  endtask

  task automatic test_saturation();
    do_reset();
    ordy = 1;
    din[0] = 32'h7FFF_FFFF; din[1] = 32'h8000_0000; vin = 1;
    tick();
    din[0] = 32'h0400_0000; din[1] = '0;
    tick();
    vin = 0;
    checks++; if (out_data !== 256'h807F || out_sat !== 1'b1) begin errors++; $display("FAIL sat_vec: got %h sat=%b expected 807f sat=1", out_data, out_sat); end
    tick();
    checks++; if (out_data !== 256'h10 || out_sat !== 1'b0) begin errors++; $display("FAIL sat_next: got %h sat=%b expected 10 sat=0", out_data, out_sat); end
  endtask

  task automatic test_overflow();
    logic [256:0] expv [6];
    bit           exp_af;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) din[i] = rand_word();
      expv[k] = ref_vec();
      vin = 1;
      tick();
      exp_af = (((k < 4) ? k : 4) + 1) >= 3;
      checks++; if (almost_full !== exp_af) begin errors++; $display("FAIL ovf_af%0d: got %b expected %b", k, almost_full, exp_af); end
    end
    vin = 0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drops: got %0d expected 2", drop_count); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    ordy = 1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (out_valid !== 1'b1 || {out_sat, out_data} !== expv[j]) begin errors++; $display("FAIL ovf_drain%0d: got %b/%h expected %h", j, out_valid, {out_sat, out_data}, expv[j]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", out_valid); end
    clr = 1;
    tick();
    clr = 0;
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL ovf_clear: got %b/%0d expected 0/0", overflow, drop_count); end
  endtask

  task automatic test_full_pushpop();
    logic [256:0] expv [5];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 32; i++) din[i] = rand_word();
      expv[k] = ref_vec();
      vin = 1;
      tick();
    end
    vin = 0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL pp_full: got %0d expected 4", fifo_level); end
    ordy = 1;
    tick();
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level: got %0d expected 4", fifo_level); end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL pp_nodrop: got %b/%0d expected 0/0", overflow, drop_count); end
    for (int j = 1; j < 5; j++) begin
      checks++; if ({out_sat, out_data} !== expv[j]) begin errors++; $display("FAIL pp_order%0d: got %h expected %h", j, {out_sat, out_data}, expv[j]); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [255:0] e;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) din[i] = rand_word();
      vin = 1;
      tick();
    end
    vin = 0;
    tick();
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL arst_pre: got %0d expected 3", fifo_level); end
    #3 rst_n = 0;
    #1;
    checks++; if ({out_valid, out_sat, almost_full, overflow} !== 4'b0) begin errors++; $display("FAIL arst_flags: got %b expected 0000", {out_valid, out_sat, almost_full, overflow}); end
    checks++; if (out_data !== '0 || fifo_level !== 3'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL arst_vals: got %h/%0d/%0d expected 0", out_data, fifo_level, drop_count); end
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    clear_inputs();
    din[5] = 32'h0400_0000; vin = 1;
    tick();
    clear_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_early: got %b expected 0", out_valid); end
    tick();
    e = 256'h10;
    e = e << 40;
    checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL arst_vec: got %b/%h expected 1/%h", out_valid, out_data, e); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      vin = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 32; i++) din[i] = rand_word();
      ordy = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      tick();
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if ({out_sat, out_data} !== mq[0]) begin errors++; $display("FAIL rnd_head@%0d: got %h expected %h", c, {out_sat, out_data}, mq[0]); end
      end
      checks++; if (fifo_level !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d expected %0d", c, fifo_level, mq.size()); end
      checks++; if (almost_full !== ((mq.size() + int'(m_s1v)) >= 3)) begin errors++; $display("FAIL rnd_af@%0d: got %b", c, almost_full); end
      checks++; if (overflow !== m_ovf || drop_count !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop@%0d: got %b/%0d expected %b/%0d", c, overflow, drop_count, m_ovf, m_drop); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_unity();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_pushpop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
